wptr_full_level: RTL and testbench

- Write-side pointer and flag generator for the dual-clock async FIFO. Lives in the wclk domain.
- Produces the binary RAM write address and the Gray write pointer for crossing to the read domain.
- Produces a registered full flag, a fill level, a programmable almost-full flag and a sticky overflow error. All are computed against the read pointer after its 2-flop synchronization into wclk.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/wptr_full_level.sv | 63 ++++++
 tb/tb_wptr_full_level.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer helpers for the dual-clock async FIFO
package fifo_pkg;

  localparam int PTR_MAX_W = 32;
  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic int fifo_depth(input int addrsize);
    return 1 << addrsize;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended inputs decode correctly: bits above the pointer XOR in as 0.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_level.sv
// rtl/wptr_full_level.sv - write-side pointer, full/almost-full/level/overflow flags
module wptr_full_level
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = 4
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE:0]   afull_thresh,
  input  logic                ovf_clr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                wafull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  localparam int PW         = ADDRSIZE + 1;
  localparam int FIFO_DEPTH = fifo_depth(ADDRSIZE);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbnext;
  logic [ADDRSIZE:0] wgnext;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] level_next;
  logic              full_next;

  assign wen        = winc & ~wfull;
  assign waddr      = wbin[ADDRSIZE-1:0];
  assign wbnext     = wbin + {{ADDRSIZE{1'b0}}, wen};
  assign wgnext     = PW'(bin2gray(ptr_t'(wbnext)));
  assign rbin_s     = PW'(gray2bin(ptr_t'(wq2_rptr)));
  assign level_next = wbnext - rbin_s;

  // Full when the pointers differ only in the wrap bit; in Gray that flips the top two bits.
  assign full_next  = (wgnext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin   <= '0;
      wptr   <= '0;
      wfull  <= 1'b0;
      wafull <= 1'b0;
      wlevel <= '0;
      wovf   <= 1'b0;
    end else begin
      wbin   <= wbnext;
      wptr   <= wgnext;
      wfull  <= full_next;
      wafull <= (level_next >= afull_thresh);
      wlevel <= level_next;
      wovf   <= (wovf & ~ovf_clr) | (winc & wfull);
    end
  end

  full_matches_level: assert property (@(posedge wclk) disable iff (!wrst_n)
    wfull == (wlevel == PW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_wptr_full_level.sv
// tb/tb_wptr_full_level.sv - scoreboard bench for wptr_full_level against a word-count model
module tb_wptr_full_level;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b0;
  logic          winc = 1'b0;
  logic [AW:0]   wq2_rptr = '0;
  logic [AW:0]   afull_thresh = '0;
  logic          ovf_clr = 1'b0;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          wafull;
  logic [AW:0]   wlevel;
  logic          wovf;

  wptr_full_level #(.ADDRSIZE(AW)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
    .afull_thresh(afull_thresh), .ovf_clr(ovf_clr), .wen(wen), .waddr(waddr),
    .wptr(wptr), .wfull(wfull), .wafull(wafull), .wlevel(wlevel), .wovf(wovf)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    bit acc;
    bit first;
    int waddr;
    int wptr;
    bit wfull;
    bit wafull;
    int wlevel;
    bit wovf;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Model state: words ever written and words ever read, as plain counts.
  int  m_wr = 0;
  bit  m_full = 0;
  bit  m_ovf = 0;
  bit  m_first = 1;

  function automatic int gray5(input int v);
    int b;
    b = v % 32;
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input bit inc, input bit clr, input int rd, input int thr);
    exp_t e;
    int   lvl;
    @(negedge wclk);
    winc         = inc;
    ovf_clr      = clr;
    wq2_rptr     = 5'(gray5(rd));
    afull_thresh = 5'(thr);
    e.acc    = inc && !m_full;
    e.first  = m_first;
    m_first  = 0;
    m_ovf    = (m_ovf && !clr) || (inc && m_full);
    m_wr     = m_wr + (e.acc ? 1 : 0);
    lvl      = m_wr - rd;
    m_full   = (lvl == DEPTH);
    e.waddr  = m_wr % DEPTH;
    e.wptr   = gray5(m_wr);
    e.wfull  = m_full;
    e.wafull = (lvl >= thr);
    e.wlevel = lvl;
    e.wovf   = m_ovf;
    exp_q.push_back(e);
  endtask

  // Monitor: wen is sampled mid-low-phase, registered outputs just after the edge.
  initial begin
    exp_t e;
    bit   wen_pre;
    int   last_wptr;
    last_wptr = 0;
    forever begin
      @(negedge wclk);
      #2;
      wen_pre = wen;
      @(posedge wclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wen", int'(wen_pre), int'(e.acc));
        chk("waddr", int'(waddr), e.waddr);
        chk("wptr", int'(wptr), e.wptr);
        chk("wfull", int'(wfull), int'(e.wfull));
        chk("wafull", int'(wafull), int'(e.wafull));
        chk("wlevel", int'(wlevel), e.wlevel);
        chk("wovf", int'(wovf), int'(e.wovf));
        if (!e.first)
          chk("gray_step", $countones(int'(wptr) ^ last_wptr), e.acc ? 1 : 0);
        last_wptr = int'(wptr);
      end
    end
  end

  task automatic do_reset();
    @(negedge wclk);
    winc = 0; ovf_clr = 0; wq2_rptr = '0;
    wrst_n = 0;
    @(negedge wclk);
    wrst_n = 1;
    m_wr = 0; m_full = 0; m_ovf = 0; m_first = 1;
  endtask

  task automatic drain();
    @(posedge wclk);
    #3;
  endtask

  initial begin
    int rd;
    int thr;
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rd;
    int thr;
    #2;
    chk("rst_wptr", int'(wptr), 0);
    chk("rst_wlevel", int'(wlevel), 0);
    chk("rst_flags", int'({wfull, wafull, wovf}), 0);
    @(negedge wclk);
    wrst_n = 1;

    // Fill from empty past full.
    for (int i = 0; i < 20; i++) step(1, 0, 0, 12);
    // Overflow clear, then simultaneous set and clear.
    step(0, 1, 0, 12);
    step(0, 0, 0, 12);
    step(1, 1, 0, 12);
    // Full release after one read.
    step(1, 0, 1, 12);
    step(1, 0, 1, 12);
    step(1, 0, 1, 12);
    drain();

    // Wrap with a read pointer trailing by four.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8);
    for (int i = 0; i < 40; i++) step(1, 0, m_wr + 1 - 4, 8);
    drain();

    // Threshold edges.
    do_reset();
    step(0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(1, 0, 0, 17);
    drain();

    // Random traffic with an async reset landing between edges.
    do_reset();
    rd = 0;
    for (int i = 0; i < 300; i++) begin
      if (rd < m_wr && ($urandom % 2) == 1) rd++;
      thr = int'($urandom_range(0, 17));
      step(($urandom % 4) != 0, ($urandom % 10) == 0, rd, thr);
    end
    drain();
    #2;
    winc = 0;
    wrst_n = 0;
    #1;
    chk("arst_wptr", int'(wptr), 0);
    chk("arst_waddr", int'(waddr), 0);
    chk("arst_wlevel", int'(wlevel), 0);
    chk("arst_flags", int'({wen, wfull, wafull, wovf}), 0);
    @(negedge wclk);
    wrst_n = 1;
    m_wr = 0; m_full = 0; m_ovf = 0; m_first = 1;
    chk("first_waddr", int'(waddr), 0);
    step(1, 0, 0, 8);
    step(1, 0, 0, 8);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
